uart_cmd_sequencer: RTL and testbench
=====================================

Name: uart_cmd_sequencer

Overview:
Frame controller between the UART receiver and the ALU.
- Consumes the receiver's byte stream and hunts for a header byte.
- Assembles opcode, operand A and operand B, then checks the frame.
- Issues one ALU command over a valid/ready handshake.
- Applies inter-byte timeout, opcode range check and overrun detection, and reports each as a one-cycle error pulse.

Parameters:
- CLOCK_FREQ, 50000000, system clock frequency in Hz (documentation and timeout derivation).
- TIMEOUT_CYCLES, 500000, maximum idle cycles between bytes inside a frame (10 ms at 50 MHz).
- HEADER, 8'hA5, start-of-frame byte.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst_n  in  1  asynchronous active-low reset.
- rx_data  in  8  byte from the UART receiver.
- rx_valid  in  1  one-cycle strobe; rx_data is valid on this cycle.
- cmd_op  out  4  ALU opcode.
- cmd_a  out  8  operand A.
- cmd_b  out  8  operand B.
- cmd_valid  out  1  command available.
- cmd_ready  in  1  ALU accepts the command.
- err_timeout  out  1  pulse: frame aborted by inter-byte timeout.
- err_opcode  out  1  pulse: opcode byte had bits [7:4] nonzero.
- err_overrun  out  1  pulse: byte arrived while a command was pending.
- frame_count  out  8  count of completed handshakes, wraps 255 to 0.

Behaviour:
- Reset: one clock clk; reset rst_n is asynchronous and active-low. While reset is asserted, all outputs are 0, the state is IDLE and the timeout counter is 0. Reset asserted mid-frame or mid-handshake discards everything immediately.
- States and transitions:
  - IDLE: on rx_valid with rx_data==HEADER, go to GET_OP. Any other byte is ignored with no error.
  - GET_OP: on rx_valid, go to GET_A if rx_data[7:4]==0, latching rx_data[3:0]. Otherwise pulse err_opcode and go to IDLE.
  - GET_A: on rx_valid, latch cmd_a and go to GET_B.
  - GET_B: on rx_valid, latch cmd_b and go to ISSUE (or GET_CK when the optional feature is compiled in).
  - ISSUE: cmd_valid=1. On cmd_valid&&cmd_ready, go to IDLE, drop cmd_valid the next cycle and increment frame_count.
- Latency: cmd_valid rises on the cycle after the rx_valid of the last frame byte.
- Data bytes equal to HEADER inside GET_* states are data, not a resync.
- Stability: cmd_op, cmd_a and cmd_b are stable while cmd_valid && !cmd_ready. They hold their last values after the handshake; they are not cleared.
- cmd_ready while cmd_valid=0 has no effect.
- Timeout:
  - The counter runs only in GET_* states and clears on every accepted byte and on entry to IDLE.
  - When it reaches TIMEOUT_CYCLES-1 with no rx_valid, err_timeout pulses and the state goes to IDLE.
  - If rx_valid coincides with expiry, the byte is accepted and there is no timeout.
  - The counter must be at least 20 bits wide.
- Overrun:
  - rx_valid in ISSUE pulses err_overrun and the byte is dropped.
  - If cmd_ready coincides with that rx_valid, the handshake completes and the byte is still dropped. The next frame must begin with a fresh header.
- Error pulses are exactly one cycle wide, registered, and mutually exclusive per cycle.

Optional Feature:
- Macro UART_SEQ_CHECKSUM_EN.
- Defined:
  - Frame is HEADER, OP, A, B, CK. CK must equal OP^A^B, computed over the full opcode byte.
  - GET_CK goes to ISSUE on a match. On a mismatch it pulses the extra output err_checksum (1 bit, reset 0) and goes to IDLE; cmd_* registers are not updated visibly (cmd_valid stays 0).
  - GET_CK takes part in the timeout.
- Undefined: 4-byte frame, no GET_CK state, no err_checksum port.

Decomposition:
- Package uart_seq_pkg holds:
  - the state enum typedef (IDLE, GET_OP, GET_A, GET_B, GET_CK, ISSUE);
  - the default HEADER;
  - the opcode width constant (4).
- One natural sub-module, uart_seq_timeout: a loadable down-counter with clear and expire outputs.

Test Plan:
- Send A5,03,12,34 with cmd_ready tied 1 -> one-cycle cmd_valid with op=3, a=0x12, b=0x34; frame_count goes 0 to 1.
- Send A5,05,A5,FF with cmd_ready held 0 for 10 cycles -> cmd_valid high 10+ cycles, outputs stable with a=0xA5 and b=0xFF; the handshake completes on the first ready cycle.
- Send A5,02 then idle for TIMEOUT_CYCLES (override to 100) -> err_timeout pulses once, state is IDLE, and a following full frame succeeds.
- Send A5,13 -> err_opcode pulses; a following frame A5,01,01,01 yields op=1.
- With a command pending, send byte 0x55 -> err_overrun pulses, and after ready the next cmd matches only a fresh header frame.
- Assert rst_n low mid-frame after A5,04 -> all outputs 0; then A5,04,01,02 with checksum enabled and CK=07 gives op=4; a frame with CK=00 pulses err_checksum.

Source files
------------

// File: rtl/uart_seq_pkg.sv
// uart_seq_pkg: shared state encoding and constants for the UART command sequencer.
// The GET_CK state is only reachable when UART_SEQ_CHECKSUM_EN is defined.
package uart_seq_pkg;

    localparam logic [7:0] HEADER_DEF = 8'hA5;
    localparam int OP_W = 4;
    localparam int MIN_TMO_W = 20;

    typedef enum logic [2:0] {
        IDLE,
        GET_OP,
        GET_A,
        GET_B,
        GET_CK,
        ISSUE
    } seq_state_t;

    function automatic int tmo_width(input int cycles);
        return ($clog2(cycles) > MIN_TMO_W) ? $clog2(cycles) : MIN_TMO_W;
    endfunction

endpackage

// File: rtl/uart_cmd_sequencer_if.sv
// uart_cmd_sequencer_if: valid/ready command bus from the sequencer to the ALU.
// master drives the command, slave returns cmd_ready.
interface uart_cmd_sequencer_if;
    import uart_seq_pkg::*;

    logic [OP_W-1:0] cmd_op;
    logic [7:0]      cmd_a;
    logic [7:0]      cmd_b;
    logic            cmd_valid;
    logic            cmd_ready;

    modport master (
        output cmd_op,
        output cmd_a,
        output cmd_b,
        output cmd_valid,
        input  cmd_ready
    );

    modport slave (
        input  cmd_op,
        input  cmd_a,
        input  cmd_b,
        input  cmd_valid,
        output cmd_ready
    );

endinterface

// File: rtl/uart_seq_timeout.sv
// uart_seq_timeout: loadable down-counter for the inter-byte timeout.
// Priority is clr > load > en; expire flags a count of zero.
module uart_seq_timeout #(
    parameter int unsigned   W    = 20,
    parameter logic [W-1:0]  LOAD = '0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic load,
    input  logic en,
    output logic expire
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= LOAD;
        end else if (en && cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign expire = (cnt == '0);

endmodule

// File: rtl/uart_cmd_sequencer.sv
// uart_cmd_sequencer: hunts for HEADER, assembles OP/A/B and issues one ALU command.
// Define UART_SEQ_CHECKSUM_EN for a trailing CK byte (OP^A^B) and the err_checksum pulse.
module uart_cmd_sequencer
    import uart_seq_pkg::*;
#(
    parameter int         CLOCK_FREQ     = 50000000,
    parameter int         TIMEOUT_CYCLES = CLOCK_FREQ / 100,
    parameter logic [7:0] HEADER         = HEADER_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    uart_cmd_sequencer_if.master cmd,
    output logic       err_timeout,
    output logic       err_opcode,
    output logic       err_overrun,
`ifdef UART_SEQ_CHECKSUM_EN
    output logic       err_checksum,
`endif
    output logic [7:0] frame_count
);

    localparam int TW = tmo_width(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TLOAD = TW'(TIMEOUT_CYCLES - 1);

    seq_state_t state, state_nx;

    logic [OP_W-1:0] op_q;
    logic [7:0]      a_q;
    logic [OP_W-1:0] op_r;
    logic [7:0]      a_r;
    logic [7:0]      b_r;
    logic [7:0]      b_src;
    logic            acc;
    logic            latch_cmd;
    logic            to_nx, oc_nx, ov_nx, ck_nx;
    logic            in_get, nx_get;
    logic            tmo_exp, tmo_clr, tmo_load, tmo_en;

`ifdef UART_SEQ_CHECKSUM_EN
    logic [7:0] b_q;
    logic [7:0] ck_exp;
    assign ck_exp = {{(8-OP_W){1'b0}}, op_q} ^ a_q ^ b_q;
    assign b_src  = b_q;
`else
    assign b_src  = rx_data;
`endif

    assign in_get = (state == GET_OP) || (state == GET_A) ||
                    (state == GET_B)  || (state == GET_CK);
    assign nx_get = (state_nx == GET_OP) || (state_nx == GET_A) ||
                    (state_nx == GET_B)  || (state_nx == GET_CK);

    // Counter is idle (zero) outside GET_*; reloaded on every accepted byte.
    assign tmo_clr  = !nx_get;
    assign tmo_load = acc && nx_get;
    assign tmo_en   = in_get && !rx_valid;

    uart_seq_timeout #(
        .W    (TW),
        .LOAD (TLOAD)
    ) u_tmo (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (tmo_clr),
        .load   (tmo_load),
        .en     (tmo_en),
        .expire (tmo_exp)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        acc       = 1'b0;
        latch_cmd = 1'b0;
        to_nx     = 1'b0;
        oc_nx     = 1'b0;
        ov_nx     = 1'b0;
        ck_nx     = 1'b0;
        unique case (state)
            IDLE: begin
                if (rx_valid && rx_data == HEADER) begin
                    acc      = 1'b1;
                    state_nx = GET_OP;
                end
            end
            GET_OP: begin
                if (rx_valid) begin
                    acc = 1'b1;
                    if (rx_data[7:OP_W] == '0) begin
                        state_nx = GET_A;
                    end else begin
                        oc_nx    = 1'b1;
                        state_nx = IDLE;
                    end
                end else if (tmo_exp) begin
                    to_nx    = 1'b1;
                    state_nx = IDLE;
                end
            end
            GET_A: begin
                if (rx_valid) begin
                    acc      = 1'b1;
                    state_nx = GET_B;
                end else if (tmo_exp) begin
                    to_nx    = 1'b1;
                    state_nx = IDLE;
                end
            end
            GET_B: begin
                if (rx_valid) begin
                    acc = 1'b1;
`ifdef UART_SEQ_CHECKSUM_EN
                    state_nx = GET_CK;
`else
                    latch_cmd = 1'b1;
                    state_nx  = ISSUE;
`endif
                end else if (tmo_exp) begin
                    to_nx    = 1'b1;
                    state_nx = IDLE;
                end
            end
            GET_CK: begin
`ifdef UART_SEQ_CHECKSUM_EN
                if (rx_valid) begin
                    acc = 1'b1;
                    if (rx_data == ck_exp) begin
                        latch_cmd = 1'b1;
                        state_nx  = ISSUE;
                    end else begin
                        ck_nx    = 1'b1;
                        state_nx = IDLE;
                    end
                end else if (tmo_exp) begin
                    to_nx    = 1'b1;
                    state_nx = IDLE;
                end
`else
                state_nx = IDLE;
`endif
            end
            ISSUE: begin
                // Bytes here are dropped even if the handshake completes now.
                ov_nx = rx_valid;
                if (cmd.cmd_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q        <= '0;
            a_q         <= '0;
            op_r        <= '0;
            a_r         <= '0;
            b_r         <= '0;
            frame_count <= '0;
            err_timeout <= 1'b0;
            err_opcode  <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            if (state == GET_OP && rx_valid) begin
                op_q <= rx_data[OP_W-1:0];
            end
            if (state == GET_A && rx_valid) begin
                a_q <= rx_data;
            end
            if (latch_cmd) begin
                op_r <= op_q;
                a_r  <= a_q;
                b_r  <= b_src;
            end
            if (state == ISSUE && cmd.cmd_ready) begin
                frame_count <= frame_count + 8'd1;
            end
            err_timeout <= to_nx;
            err_opcode  <= oc_nx;
            err_overrun <= ov_nx;
        end
    end

`ifdef UART_SEQ_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_q          <= '0;
            err_checksum <= 1'b0;
        end else begin
            if (state == GET_B && rx_valid) begin
                b_q <= rx_data;
            end
            err_checksum <= ck_nx;
        end
    end
`else
    logic unused_ck;
    assign unused_ck = ck_nx;
`endif

    assign cmd.cmd_op    = op_r;
    assign cmd.cmd_a     = a_r;
    assign cmd.cmd_b     = b_r;
    assign cmd.cmd_valid = (state == ISSUE);

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// tb_uart_cmd_sequencer: directed frames plus randomized byte stream against a queue-based model.
// Build with UART_SEQ_CHECKSUM_EN defined to exercise the CK byte.
module tb_uart_cmd_sequencer;

    localparam int T = 100;
    localparam logic [7:0] HDR = 8'hA5;
`ifdef UART_SEQ_CHECKSUM_EN
    localparam int FLEN = 5;
`else
    localparam int FLEN = 4;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       err_timeout, err_opcode, err_overrun;
    logic [7:0] frame_count;
`ifdef UART_SEQ_CHECKSUM_EN
    logic       err_checksum;
`endif

    int checks = 0;
    int errors = 0;

    uart_cmd_sequencer_if cif ();

    uart_cmd_sequencer #(
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .cmd          (cif.master),
        .err_timeout  (err_timeout),
        .err_opcode   (err_opcode),
        .err_overrun  (err_overrun),
`ifdef UART_SEQ_CHECKSUM_EN
        .err_checksum (err_checksum),
`endif
        .frame_count  (frame_count)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: bytes of the frame under assembly, idle cycles, pending command.
    logic [7:0] m_frame[$];
    int         m_idle = 0;
    logic       e_valid = 0;
    logic [3:0] e_op = 0;
    logic [7:0] e_a = 0, e_b = 0, e_cnt = 0;
    logic       e_to = 0, e_oc = 0, e_ov = 0, e_ck = 0;

    initial forever begin
        logic       ok;
        logic [7:0] t;
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_frame.delete();
            m_idle = 0;
            e_valid = 0; e_op = 0; e_a = 0; e_b = 0; e_cnt = 0;
            e_to = 0; e_oc = 0; e_ov = 0; e_ck = 0;
        end else begin
            e_to = 0; e_oc = 0; e_ov = 0; e_ck = 0;
            if (e_valid) begin
                if (rx_valid) e_ov = 1;
                if (cif.cmd_ready) begin
                    e_valid = 0;
                    e_cnt = e_cnt + 8'd1;
                end
            end else if (rx_valid) begin
                m_idle = 0;
                if (m_frame.size() == 0) begin
                    if (rx_data == HDR) m_frame.push_back(rx_data);
                end else if (m_frame.size() == 1 && rx_data[7:4] != 4'h0) begin
                    e_oc = 1;
                    m_frame.delete();
                end else begin
                    m_frame.push_back(rx_data);
                    if (m_frame.size() == FLEN) begin
                        ok = 1;
`ifdef UART_SEQ_CHECKSUM_EN
                        ok = (m_frame[4] == (m_frame[1] ^ m_frame[2] ^ m_frame[3]));
`endif
                        if (ok) begin
                            t = m_frame[1];
                            e_op = t[3:0];
                            e_a = m_frame[2];
                            e_b = m_frame[3];
                            e_valid = 1;
                        end else begin
                            e_ck = 1;
                        end
                        m_frame.delete();
                    end
                end
            end else if (m_frame.size() != 0) begin
                m_idle++;
                if (m_idle == T) begin
                    e_to = 1;
                    m_frame.delete();
                    m_idle = 0;
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        cmp("cmd_valid", cif.cmd_valid, e_valid);
        cmp("cmd_op", cif.cmd_op, e_op);
        cmp("cmd_a", cif.cmd_a, e_a);
        cmp("cmd_b", cif.cmd_b, e_b);
        cmp("err_timeout", err_timeout, e_to);
        cmp("err_opcode", err_opcode, e_oc);
        cmp("err_overrun", err_overrun, e_ov);
`ifdef UART_SEQ_CHECKSUM_EN
        cmp("err_checksum", err_checksum, e_ck);
`endif
        cmp("frame_count", frame_count, e_cnt);
    end

    task automatic drive(input logic v, input logic [7:0] d, input logic r);
        @(negedge clk);
        rx_valid = v;
        rx_data = d;
        cif.cmd_ready = r;
    endtask

    task automatic frame(input logic [7:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic r);
        drive(1, HDR, r);
        drive(1, op, r);
        drive(1, a, r);
        drive(1, b, r);
`ifdef UART_SEQ_CHECKSUM_EN
        drive(1, op ^ a ^ b, r);
`endif
    endtask

    function automatic logic [7:0] rnd_byte();
        int s;
        s = $urandom_range(0, 99);
        if (s < 35) return HDR;
        if (s < 70) return {4'h0, 4'($urandom_range(0, 15))};
        if (s < 80) return {4'($urandom_range(1, 15)), 4'($urandom_range(0, 15))};
        return 8'($urandom_range(0, 255));
    endfunction

    initial begin
        int npulse, at, gap, s;
        cif.cmd_ready = 1'b0;
        repeat (3) @(negedge clk);
        cmp("rst_valid", cif.cmd_valid, 0);
        cmp("rst_count", frame_count, 0);
        rst_n = 1'b1;

        frame(8'h03, 8'h12, 8'h34, 1);
        drive(0, 0, 1);
        cmp("t1_valid", cif.cmd_valid, 1);
        cmp("t1_op", cif.cmd_op, 3);
        cmp("t1_a", cif.cmd_a, 8'h12);
        cmp("t1_b", cif.cmd_b, 8'h34);
        cmp("t1_cnt0", frame_count, 0);
        drive(0, 0, 1);
        cmp("t1_drop", cif.cmd_valid, 0);
        cmp("t1_cnt1", frame_count, 1);

        frame(8'h05, 8'hA5, 8'hFF, 0);
        for (int i = 0; i < 10; i++) begin
            drive(0, 0, 0);
            cmp("t2_hold", cif.cmd_valid, 1);
            cmp("t2_a", cif.cmd_a, 8'hA5);
            cmp("t2_b", cif.cmd_b, 8'hFF);
        end
        drive(0, 0, 1);
        drive(0, 0, 0);
        cmp("t2_drop", cif.cmd_valid, 0);
        cmp("t2_cnt", frame_count, 2);

        drive(1, HDR, 0);
        drive(1, 8'h02, 0);
        npulse = 0;
        at = 0;
        for (int k = 1; k <= T + 2; k++) begin
            drive(0, 0, 0);
            if (err_timeout) begin
                npulse++;
                at = k;
            end
        end
        cmp("t3_pulses", npulse, 1);
        cmp("t3_at", at, T + 1);
        frame(8'h07, 8'h01, 8'h02, 1);
        drive(0, 0, 1);
        cmp("t3_after", cif.cmd_valid, 1);

        drive(1, HDR, 1);
        drive(1, 8'h13, 1);
        drive(0, 0, 1);
        cmp("t4_opcode", err_opcode, 1);
        drive(0, 0, 1);
        cmp("t4_pulse1", err_opcode, 0);
        frame(8'h01, 8'h01, 8'h01, 1);
        drive(0, 0, 1);
        cmp("t4_op", cif.cmd_op, 1);

        frame(8'h06, 8'h11, 8'h22, 0);
        drive(1, 8'h55, 0);
        drive(0, 0, 0);
        cmp("t5_overrun", err_overrun, 1);
        cmp("t5_pending", cif.cmd_valid, 1);
        drive(0, 0, 1);
        drive(1, 8'h01, 0);
        drive(1, 8'h02, 0);
        drive(1, 8'h03, 0);
        drive(0, 0, 0);
        cmp("t5_nohdr", cif.cmd_valid, 0);
        frame(8'h08, 8'h09, 8'h0A, 1);
        drive(0, 0, 1);
        cmp("t5_op", cif.cmd_op, 8);
        cmp("t5_b", cif.cmd_b, 8'h0A);

        drive(1, HDR, 0);
        drive(1, 8'h04, 0);
        drive(0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        cmp("t6_count", frame_count, 0);
        cmp("t6_a", cif.cmd_a, 0);
        cmp("t6_valid", cif.cmd_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        frame(8'h04, 8'h01, 8'h02, 1);
        drive(0, 0, 1);
        cmp("t6_op", cif.cmd_op, 4);
`ifdef UART_SEQ_CHECKSUM_EN
        drive(1, HDR, 1);
        drive(1, 8'h04, 1);
        drive(1, 8'h01, 1);
        drive(1, 8'h02, 1);
        drive(1, 8'h00, 1);
        drive(0, 0, 1);
        cmp("t6_cksum", err_checksum, 1);
        cmp("t6_ck_valid", cif.cmd_valid, 0);
`endif

        for (int it = 0; it < 1200; it++) begin
            s = $urandom_range(0, 99);
            if (s < 82) gap = $urandom_range(0, 3);
            else if (s < 88) gap = T - 1;
            else if (s < 94) gap = T;
            else gap = T - 2;
            for (int g = 0; g < gap; g++) begin
                drive(0, 8'h00, ($urandom_range(0, 9) < 4));
            end
            drive(1, rnd_byte(), ($urandom_range(0, 9) < 4));
        end
        repeat (5) drive(0, 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
